gardner_timing_ctrl: RTL and testbench
======================================

Name: gardner_timing_ctrl

Overview:
- Closes the symbol-timing recovery loop around interpolate_filter.
- Consumes the interpolator outputs I_y/Q_y and applies a Gardner timing-error detector (TED) and a PI loop filter.
- Drives a modulo-1 decrementing NCO that generates the interpolation strobe and the fractional interval uk fed back to the interpolator.
- Emits decimated on-time symbols (1 per symbol, 2 interpolants per symbol) to the downstream decision/carrier stage.

Parameters:
- W0, 16'h8000: nominal NCO step (1/samples-per-interpolant, 16 fractional bits; 0.5 = 4 samples/symbol).
- W_LIM, 16'h0800: maximum magnitude of the loop correction v; also the integrator clamp.
- KP_SHIFT, 12: proportional gain = 2^-KP_SHIFT.
- KI_SHIFT, 18: integral gain = 2^-KI_SHIFT.
- INTERP_LAT, 3: clk cycles from a uk/strobe update to the matching valid I_y/Q_y.

Ports:
- clk, input, 1: system clock, one input sample per cycle.
- rst_n, input, 1: asynchronous active-low reset.
- loop_en, input, 1: 1 = loop closed; 0 = v forced to 0, integrator held at 0.
- I_y, input, 20: I interpolant, signed.
- Q_y, input, 20: Q interpolant, signed.
- uk, output, 16: fractional interval, 15 fractional bits, range [0, 16'h7FFF].
- strobe, output, 1: interpolant-request pulse, aligned with the uk update.
- sym_I, output, 20: on-time I symbol.
- sym_Q, output, 20: on-time Q symbol.
- sym_valid, output, 1: one-cycle pulse, sym_I/sym_Q valid.
- ted_err, output, 26: last Gardner error, signed, debug.

Behaviour:
- Reset (async, rst_n=0): eta=0, uk=0, strobe=0, sym_I=0, sym_Q=0, sym_valid=0, ted_err=0, acc=0, v=0, phase=0, prev/mid registers=0, latency pipe cleared.
- Reset asserted mid-operation clears all state immediately. The first strobe occurs on the first clk edge after release, because eta=0 < W.

NCO:
- W = W0 + v, 17-bit arithmetic. Since |v| ≤ W_LIM, W stays within [W0-W_LIM, W0+W_LIM].
- Each clk: eta <= (eta - W) mod 2^16.
- strobe <= (eta < W), comparing the pre-update eta.
- When eta < W: uk <= min(eta, 16'h7FFF), using the pre-update eta. Otherwise uk holds its value.
- Equality eta == W is not a strobe.

Capture:
- strobe is delayed INTERP_LAT cycles through a shift register to give cap.
- When cap=1, I_y/Q_y are captured.
- phase toggles on every cap. The first cap after reset is on-time (phase=0); subsequent caps alternate midpoint, on-time, and so on.
- Midpoint cap: midI <= I_y[19:8], midQ <= Q_y[19:8] (12-bit signed).

On-time cap (single edge, all updates simultaneous):
- Operands: curI = I_y[19:8], curQ = Q_y[19:8].
- e = midI*(curI - prevI) + midQ*(curQ - prevQ). Differences are 13-bit, products 25-bit, sum 26-bit signed.
- ted_err <= e.
- Integrator (loop_en=1): acc <= clamp(acc + (e >>> KI_SHIFT), ±W_LIM). Arithmetic shifts are on e sign-extended to 32 bits.
- Loop output (loop_en=1): v <= clamp((e >>> KP_SHIFT) + acc_new, ±W_LIM).
- loop_en=0: acc <= 0, v <= 0. ted_err still updates.
- prevI <= curI, prevQ <= curQ.
- sym_I <= I_y, sym_Q <= Q_y, sym_valid <= 1.
- sym_valid is 0 on all other cycles.
- The first on-time cap after reset uses prev=0 and mid=0, so e=0.

General:
- A new v takes effect on W in the cycle after the update.
- Loop sign: a late sampling instant gives e > 0, which increases W and advances the strobes.
- strobe and cap may coincide. Both are processed; no stall, no backpressure.

Test Plan:
1. loop_en=0, W0=16'h8000 -> strobe=1 every second cycle starting the first edge after reset, uk=0 each strobe, sym_valid every 4th cycle.
2. loop_en=0, W0=16'h6000 -> eta sequence 0,A000,4000,E000,8000,2000,C000,6000,0. Strobes with uk = 0000, 4000, 2000, 0000 at cycles 0, 2, 5, 8. Note eta=6000 gives no strobe (equality).
3. Force on-time prev I_y[19:8]=-1000, mid=+500, cur=+1000, Q path all 0 -> ted_err = 1,000,000. With loop_en=1 and defaults: acc=3, v=247, next W=16'h80F7.
4. Constant large positive e (e.g. repeated test-3 symbols), loop_en=1 -> acc and v saturate at +16'h0800, W never exceeds 16'h8800, no wrap to negative.
5. Assert rst_n low for 1 cycle between edges mid-operation with v≠0 -> all outputs 0 immediately. After release, the first strobe lands on the next edge, uk=0, and the first sym_valid yields ted_err=0.
6. loop_en toggled 1->0 with v≠0 -> on the next on-time cap v=0 and acc=0, and W returns to W0 one cycle later.

Source files
------------

// File: rtl/gardner_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gardner_timing_ctrl                                                      |
// | Gardner TED + PI loop filter + modulo-1 NCO closing the symbol-timing    |
// | loop around the interpolator; emits one on-time symbol per two strobes.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gardner_timing_ctrl #(
    parameter logic [15:0] W0         = 16'h8000,
    parameter logic [15:0] W_LIM      = 16'h0800,
    parameter int          KP_SHIFT   = 12,
    parameter int          KI_SHIFT   = 18,
    parameter int          INTERP_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               loop_en,
    input  logic signed [19:0] I_y,
    input  logic signed [19:0] Q_y,
    output logic        [15:0] uk,
    output logic               strobe,
    output logic signed [19:0] sym_I,
    output logic signed [19:0] sym_Q,
    output logic               sym_valid,
    output logic signed [25:0] ted_err
);

    localparam logic signed [31:0] c_lim   = $signed({16'd0, W_LIM});
    localparam logic signed [31:0] c_lim_n = -c_lim;

    logic        [15:0]         r_eta;
    logic        [15:0]         r_uk;
    logic                       r_strobe;
    logic        [INTERP_LAT-1:0] r_pipe;
    logic                       r_phase;
    logic signed [11:0]         r_mid_i, r_mid_q, r_prev_i, r_prev_q;
    logic signed [19:0]         r_sym_i, r_sym_q;
    logic                       r_sym_valid;
    logic signed [25:0]         r_ted_err;
    logic signed [16:0]         r_acc, r_v;

    logic        [16:0]         w_w;
    logic                       w_strobe;
    logic                       w_cap;
    logic signed [11:0]         w_cur_i, w_cur_q;
    logic signed [12:0]         w_d_i, w_d_q;
    logic signed [24:0]         w_p_i, w_p_q;
    logic signed [25:0]         w_e;
    logic signed [31:0]         w_e32, w_acc_sum, w_v_sum;
    logic signed [16:0]         w_acc_new, w_v_new;

    function automatic logic signed [16:0] f_clamp(input logic signed [31:0] x);
        if (x > c_lim)
            f_clamp = c_lim[16:0];
        else if (x < c_lim_n)
            f_clamp = c_lim_n[16:0];
        else
            f_clamp = x[16:0];
    endfunction

    // W = W0 + v is always positive, so 17-bit wraparound addition is exact.
    assign w_w      = {1'b0, W0} + r_v;
    assign w_strobe = ({1'b0, r_eta} < w_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eta    <= 16'd0;
            r_uk     <= 16'd0;
            r_strobe <= 1'b0;
        end else begin
            r_eta    <= r_eta - w_w[15:0];
            r_strobe <= w_strobe;
            if (w_strobe)
                r_uk <= r_eta[15] ? 16'h7FFF : r_eta;
        end
    end

    generate
        if (INTERP_LAT == 1) begin : g_lat_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= r_strobe;
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= {r_pipe[INTERP_LAT-2:0], r_strobe};
            end
        end
    endgenerate

    assign w_cap = r_pipe[INTERP_LAT-1];

    // Gardner error: mid * (cur - prev), summed over I and Q.
    assign w_cur_i   = I_y[19:8];
    assign w_cur_q   = Q_y[19:8];
    assign w_d_i     = {w_cur_i[11], w_cur_i} - {r_prev_i[11], r_prev_i};
    assign w_d_q     = {w_cur_q[11], w_cur_q} - {r_prev_q[11], r_prev_q};
    assign w_p_i     = $signed({{13{r_mid_i[11]}}, r_mid_i}) * $signed({{12{w_d_i[12]}}, w_d_i});
    assign w_p_q     = $signed({{13{r_mid_q[11]}}, r_mid_q}) * $signed({{12{w_d_q[12]}}, w_d_q});
    assign w_e       = {w_p_i[24], w_p_i} + {w_p_q[24], w_p_q};
    assign w_e32     = {{6{w_e[25]}}, w_e};
    assign w_acc_sum = $signed({{15{r_acc[16]}}, r_acc}) + (w_e32 >>> KI_SHIFT);
    assign w_acc_new = f_clamp(w_acc_sum);
    assign w_v_sum   = (w_e32 >>> KP_SHIFT) + $signed({{15{w_acc_new[16]}}, w_acc_new});
    assign w_v_new   = f_clamp(w_v_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= 1'b0;
            r_mid_i     <= '0;
            r_mid_q     <= '0;
            r_prev_i    <= '0;
            r_prev_q    <= '0;
            r_sym_i     <= '0;
            r_sym_q     <= '0;
            r_sym_valid <= 1'b0;
            r_ted_err   <= '0;
            r_acc       <= '0;
            r_v         <= '0;
        end else begin
            r_sym_valid <= w_cap & ~r_phase;
            if (w_cap) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_ted_err <= w_e;
                    r_prev_i  <= w_cur_i;
                    r_prev_q  <= w_cur_q;
                    r_sym_i   <= I_y;
                    r_sym_q   <= Q_y;
                    if (loop_en) begin
                        r_acc <= w_acc_new;
                        r_v   <= w_v_new;
                    end else begin
                        r_acc <= '0;
                        r_v   <= '0;
                    end
                end else begin
                    r_mid_i <= w_cur_i;
                    r_mid_q <= w_cur_q;
                end
            end
        end
    end

    assign uk        = r_uk;
    assign strobe    = r_strobe;
    assign sym_I     = r_sym_i;
    assign sym_Q     = r_sym_q;
    assign sym_valid = r_sym_valid;
    assign ted_err   = r_ted_err;

endmodule
`default_nettype wire

// File: tb/tb_gardner_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gardner_timing_ctrl                                                   |
// | Directed bench: a latency-matched interpolator stand-in feeds queued     |
// | interpolants; hand-computed symbol records are checked at sym_valid.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_gardner_timing_ctrl;

    typedef struct {
        logic en;
        int   mi, mq, oi, oq;
        int   e;
        logic cl;
        int   acc, v;
        logic cw;
        int   w;
    } vec_t;

    typedef struct {
        logic        en;
        logic [19:0] i, q;
    } stim_t;

    typedef struct {
        int          e;
        logic [19:0] si, sq;
        logic        cl;
        int          acc, v;
        logic        cw;
        int          w;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               loop_en;
    logic signed [19:0] I_y, Q_y;
    logic        [15:0] uk;
    logic               strobe;
    logic signed [19:0] sym_I, sym_Q;
    logic               sym_valid;
    logic signed [25:0] ted_err;

    logic               loop_en2;
    logic signed [19:0] I_y2, Q_y2;
    logic        [15:0] uk2;
    logic               strobe2;
    logic signed [19:0] sym_I2, sym_Q2;
    logic               sym_valid2;
    logic signed [25:0] ted_err2;

    int    total = 0;
    int    bad   = 0;
    logic  [3:0] hist;
    logic  mon_w;
    stim_t sq[$];
    exp_t  eq[$];
    vec_t  tv[8];

    logic        [15:0] uk2_tab  [9] = '{16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h4000,
                                         16'h2000, 16'h2000, 16'h2000, 16'h0000};
    logic               stb2_tab [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    gardner_timing_ctrl dut (
        .clk(clk), .rst_n(rst_n), .loop_en(loop_en), .I_y(I_y), .Q_y(Q_y),
        .uk(uk), .strobe(strobe), .sym_I(sym_I), .sym_Q(sym_Q),
        .sym_valid(sym_valid), .ted_err(ted_err)
    );

    gardner_timing_ctrl #(.W0(16'h6000)) dut2 (
        .clk(clk), .rst_n(rst_n), .loop_en(loop_en2), .I_y(I_y2), .Q_y(Q_y2),
        .uk(uk2), .strobe(strobe2), .sym_I(sym_I2), .sym_Q(sym_Q2),
        .sym_valid(sym_valid2), .ted_err(ted_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic vec_t mk(input logic en, input int mi, input int mq, input int oi,
                                input int oq, input int e, input logic cl, input int acc,
                                input int v, input logic cw, input int w);
        vec_t r;
        r.en = en; r.mi = mi; r.mq = mq; r.oi = oi; r.oq = oq; r.e = e;
        r.cl = cl; r.acc = acc; r.v = v; r.cw = cw; r.w = w;
        return r;
    endfunction

    // First symbol after reset has no preceding midpoint slot.
    task automatic push_vec(input vec_t r, input bit first, input logic [7:0] lo);
        stim_t s;
        exp_t  x;
        if (!first) begin
            s.en = r.en; s.i = {12'(r.mi), lo}; s.q = {12'(r.mq), ~lo};
            sq.push_back(s);
        end
        s.en = r.en; s.i = {12'(r.oi), lo}; s.q = {12'(r.oq), ~lo};
        sq.push_back(s);
        x.e = r.e; x.si = s.i; x.sq = s.q; x.cl = r.cl; x.acc = r.acc; x.v = r.v;
        x.cw = r.cw; x.w = r.w;
        eq.push_back(x);
    endtask

    // One cycle: check any emitted symbol, then act as the interpolator,
    // presenting data INTERP_LAT cycles after each observed strobe.
    task automatic tick();
        exp_t  x;
        stim_t s;
        @(negedge clk);
        if (sym_valid && eq.size() > 0) begin
            x = eq.pop_front();
            chk("ted_err", ted_err, x.e);
            chk("sym_I", {12'd0, sym_I[19:0]}, {12'd0, x.si});
            chk("sym_Q", {12'd0, sym_Q[19:0]}, {12'd0, x.sq});
            if (x.cl) begin
                chk("acc", dut.r_acc, x.acc);
                chk("v", dut.r_v, x.v);
            end
            if (x.cw)
                chk("W", {15'd0, dut.w_w}, x.w);
        end
        if (mon_w) begin
            chk("W_max", {31'd0, (dut.w_w <= 17'h08800)}, 32'd1);
            chk("W_min", {31'd0, (dut.w_w >= 17'h07800)}, 32'd1);
        end
        hist = {hist[2:0], strobe};
        if (hist[3]) begin
            if (sq.size() > 0) begin
                s = sq.pop_front();
                I_y = s.i; Q_y = s.q; loop_en = s.en;
            end else begin
                I_y = '0; Q_y = '0;
            end
        end else begin
            I_y = 20'h5A5A5; Q_y = 20'hA5A5A;
        end
    endtask

    task automatic wait_syms(input int budget);
        int n = 0;
        while (eq.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("sym_timeout_left", eq.size(), 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_strobe"}, {31'd0, strobe}, 0);
        chk({tag, "_uk"}, {16'd0, uk}, 0);
        chk({tag, "_symvalid"}, {31'd0, sym_valid}, 0);
        chk({tag, "_ted"}, ted_err, 0);
        chk({tag, "_symI"}, sym_I, 0);
        chk({tag, "_symQ"}, sym_Q, 0);
        chk({tag, "_v"}, dut.r_v, 0);
        chk({tag, "_acc"}, dut.r_acc, 0);
    endtask

    initial begin
        rst_n = 1'b0; loop_en = 1'b0; I_y = '0; Q_y = '0; hist = '0; mon_w = 1'b0;
        loop_en2 = 1'b0; I_y2 = '0; Q_y2 = '0;

        tv[0] = mk(0,     0,     0,   100,   -50,         0, 0, 0,   0,   0, 0);
        tv[1] = mk(0,   300,  -200,  -100,   150,   -100000, 0, 0,   0,   0, 0);
        tv[2] = mk(0, -2048,  2047,  2047, -2048,  -8896362, 0, 0,   0,   0, 0);
        tv[3] = mk(0, -2048,  2047, -2048,  2047,  16769025, 0, 0,   0,   0, 0);
        tv[4] = mk(0,     0,     0,     5,     7,         0, 0, 0,   0,   0, 0);
        tv[5] = mk(0,     1,    -1,     4,    10,        -4, 0, 0,   0,   0, 0);
        tv[6] = mk(0,     0,     0, -1000,     0,         0, 1, 0,   0,   1, 'h8000);
        tv[7] = mk(1,   500,     0,  1000,     0,   1000000, 1, 3, 247,   1, 'h80F7);

        for (int k = 0; k < 8; k++)
            push_vec(tv[k], (k == 0), 8'(8'h11 * (k + 1)));

        // Constant large positive error drives both acc and v into the clamp.
        for (int k = 0; k < 40; k++) begin
            if (k[0] == 1'b0)
                push_vec(mk(1, -2048, 2047, -2048, 2047, (k == 0) ? 10432513 : 16769025,
                            (k == 39), 2048, 2048, 0, 0), 0, 8'h5C);
            else
                push_vec(mk(1, 2047, -2048, 2047, -2048, 16769025,
                            (k == 39), 2048, 2048, (k == 39), 'h8800), 0, 8'hC5);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t1_strobe", {31'd0, strobe}, {31'd0, (i % 2 == 0)});
            chk("t1_uk", {16'd0, uk}, 0);
            chk("t1_symvalid", {31'd0, sym_valid}, {31'd0, (i == 4 || i == 8)});
            chk("t2_strobe", {31'd0, strobe2}, {31'd0, stb2_tab[i]});
            chk("t2_uk", {16'd0, uk2}, {16'd0, uk2_tab[i]});
        end

        mon_w = 1'b1;
        wait_syms(3000);
        mon_w = 1'b0;

        // Asynchronous reset pulse between edges while v is saturated.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midreset");
        #1 rst_n = 1'b1;
        hist = '0;
        sq.delete();
        eq.delete();
        loop_en = 1'b0;

        push_vec(mk(0,   0, 0, -1000, 0,       0, 1, 0,   0, 1, 'h8000), 1, 8'h3A);
        push_vec(mk(1, 500, 0,  1000, 0, 1000000, 1, 3, 247, 1, 'h80F7), 0, 8'h4B);
        push_vec(mk(0,   3, 0,     0, 0,   -3000, 1, 0,   0, 1, 'h8000), 0, 8'h6D);

        tick();
        chk("post_rst_n0_strobe", {31'd0, strobe}, 0);
        tick();
        chk("post_rst_strobe", {31'd0, strobe}, 1);
        chk("post_rst_uk", {16'd0, uk}, 0);

        wait_syms(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
